// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//
// Shared definitions for the stopwatch controller:
//   - sw_state_t : FSM state encoding, which is also the value driven on the
//                  2-bit 'state' output (IDLE=00, RUN=01, PAUSE=10, LAP=11).
//   - SEC_MAX / TENTH_MAX : upper limits of the seconds and tenths counters.
//   - sw_time_t  : a seconds/tenths pair, used for the live time and the
//                  frozen lap snapshot.
//   - time_inc() : advances a time value by one tenth, wrapping 999.9 -> 000.0.
//   - time_is_max() : true when a time value sits at 999.9.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } sw_state_t;

    localparam int SEC_W   = 10;
    localparam int TENTH_W = 4;

    localparam logic [SEC_W-1:0]   SEC_MAX   = 10'd999;
    localparam logic [TENTH_W-1:0] TENTH_MAX = 4'd9;

    typedef struct packed {
        logic [SEC_W-1:0]   sec;
        logic [TENTH_W-1:0] tenth;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;

    // One tenth-second step. Tenths roll into seconds; seconds roll over to
    // zero after 999, so 999.9 steps to 000.0.
    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t n;
        n = t;
        if (t.tenth == TENTH_MAX) begin
            n.tenth = '0;
            n.sec   = (t.sec == SEC_MAX) ? '0 : t.sec + 1'b1;
        end else begin
            n.tenth = t.tenth + 1'b1;
        end
        return n;
    endfunction

    function automatic logic time_is_max(input sw_time_t t);
        return (t.sec == SEC_MAX) && (t.tenth == TENTH_MAX);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Prescaler that divides the input clock down to one tick per DIV enabled
// cycles. The count advances only while 'en' is high and simply holds when
// 'en' is low, so a paused stopwatch resumes mid-tenth rather than restarting
// the tenth. 'clr' forces the count to zero and wins over 'en'.
//
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   synchronous active-low reset
//   en    in   count enable
//   clr   in   synchronous clear of the prescaler
//   tick  out  high for the single cycle in which the enabled count sits at
//              DIV-1; the count returns to zero on that same edge
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the counters in the parent see the tick on the same
    // edge that wraps the prescaler back to zero.
    assign tick = en && (cnt == LAST);

    // NOTE: reset is sampled on the clock edge (synchronous); all state here is
    // plain flops, so every register is reset, and non-blocking assignments keep
    // the register update order-independent across always_ff blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Tenth-second stopwatch with run/pause, lap (display freeze) and clear.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz (multiple of 10, at least 20)
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   synchronous active-low reset
//   btn_start_stop  in   one-cycle pulse, toggles run / pause
//   btn_lap         in   one-cycle pulse, freezes / unfreezes the display
//   btn_clear       in   one-cycle pulse, zeroes the time (accepted in PAUSE)
//   running         out  high in RUN and LAP
//   lap_active      out  high in LAP
//   state           out  IDLE=00, RUN=01, PAUSE=10, LAP=11
//   disp_sec        out  displayed seconds 0..999
//   disp_tenth      out  displayed tenths 0..9
//   wrap            out  one-cycle pulse after the live time rolls 999.9->000.0
//
// Button priority when pulses coincide is clear > start_stop > lap, counting
// only buttons that have a meaning in the current state (e.g. clear in RUN is
// ignored and does not block a simultaneous start_stop).
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    output logic               running,
    output logic               lap_active,
    output logic [1:0]         state,
    output logic [SEC_W-1:0]   disp_sec,
    output logic [TENTH_W-1:0] disp_tenth,
    output logic               wrap
);

    localparam int TICK_DIV = CLK_HZ / 10;

    sw_state_t state_q;
    sw_time_t  live_q;     // live running time
    sw_time_t  snap_q;     // display value frozen on entry to LAP
    sw_time_t  live_nxt;
    logic      tick;
    logic      clear_accept;
    logic      presc_clr;

    // Clear only has an effect from PAUSE; the prescaler is also held at zero
    // throughout IDLE so a fresh start always begins a full tenth.
    assign clear_accept = (state_q == ST_PAUSE) && btn_clear;
    assign presc_clr    = (state_q == ST_IDLE) || clear_accept;

    // The prescaler is enabled from the registered 'running' flag, i.e. the
    // state before this edge. A tick landing on the same edge as start_stop
    // in RUN is therefore still counted; the count stops from the next cycle.
    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (running),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // NOTE: every signal written in an always_comb gets a value on every path
    // (here via the leading default) so no latch is inferred.
    always_comb begin
        live_nxt = live_q;
        if (clear_accept) begin
            live_nxt = TIME_ZERO;
        end else if (tick) begin
            live_nxt = time_inc(live_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            live_q     <= TIME_ZERO;
            snap_q     <= TIME_ZERO;
            wrap       <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            live_q <= live_nxt;
            // Clear cannot coincide with a tick (no tick outside RUN/LAP),
            // so the rollover condition needs no clear qualifier.
            wrap   <= tick && time_is_max(live_q);

            unique case (state_q)
                ST_IDLE: begin
                    if (btn_start_stop) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (btn_start_stop) begin
                        state_q <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (btn_lap) begin
                        state_q    <= ST_LAP;
                        lap_active <= 1'b1;
                        // Pre-tick value: the time shown at the moment lap
                        // was pressed, not the one a same-edge tick produces.
                        snap_q     <= live_q;
                    end
                end

                ST_LAP: begin
                    if (btn_start_stop) begin
                        state_q    <= ST_PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (btn_lap) begin
                        state_q    <= ST_RUN;
                        lap_active <= 1'b0;
                    end
                end

                ST_PAUSE: begin
                    if (btn_clear) begin
                        state_q <= ST_IDLE;
                    end else if (btn_start_stop) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

    // Outside LAP the display tracks the live time directly.
    assign disp_sec   = lap_active ? snap_q.sec   : live_q.sec;
    assign disp_tenth = lap_active ? snap_q.tenth : live_q.tenth;

endmodule
